sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO; the next generation of the project FIFO, generalised in data width and depth. Adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, sticky overflow/underflow error flags and a compile-time first-word-fall-through read mode. Sits between a producer and a consumer in the same clock domain and serves as the storage core for later FIFO variants.

## Interface
Parameters:
- DATA_WIDTH, 8: width of each entry in bits; must be 1 or more.
- DEPTH, 16: number of entries; must be a power of two, 2 or more.
- AF_THRESH, DEPTH-2: `almost_full` asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2: `almost_empty` asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and error flags.
- data_in  in  DATA_WIDTH  write data.
- write  in  1  write request.
- read  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH x DATA_WIDTH register array. Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Accepted write: `write && !full`. Stores data_in at wr_ptr, then increments wr_ptr.
- Accepted read: `read && !empty`. Increments rd_ptr.
- Rejected write: `write && full`. No state change except overflow is set to 1.
- Rejected read: `read && empty`. No state change except underflow is set to 1.
- Both requests in one cycle are evaluated independently against the current flags:
  - When full, the read is accepted and the write is rejected; count goes to DEPTH-1 and overflow is set.
  - When empty, the write is accepted and the read is rejected; count goes to 1 and underflow is set.
  - Otherwise both are accepted and count is unchanged.
- count: +1 on an accepted write only, -1 on an accepted read only. It never exceeds DEPTH or goes below 0.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count, so they have no extra latency.
- flush: takes priority over read and write in the same cycle.
  - Pointers, count, overflow and underflow all go to 0.
  - Memory contents are not cleared.
  - data_out goes to 0 in standard mode.
- Reset (asserted at any time, including mid-operation): immediately forces pointers = 0, count = 0, overflow = 0, underflow = 0 and data_out = 0. Memory contents are not reset.
- Reset values of the outputs: full=0, empty=1, almost_full=0 (AF_THRESH >= 1), almost_empty=1, count=0, overflow=0, underflow=0, data_out=0.

## Timing
- Write to flags: an accepted write at edge N is reflected in count and flags after edge N.
- Standard mode, read latency: an accepted read at edge N loads data_out with mem[rd_ptr] at edge N, so the data is valid after edge N. data_out holds its value until the next accepted read.
- Standard mode, write then read: data written at edge N can be read at edge N+1 at the earliest.
- Reset release: the first write may occur at the first rising edge after rst deasserts.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally whenever empty==0, and 0 when empty.
  - An accepted read pops the displayed word; the next word appears after that edge.
  - A write into an empty FIFO at edge N is visible on data_out after edge N.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as in Timing.
- All other behaviour is identical in both modes.

## Test plan
- Reset then fill: DEPTH=16, AF_THRESH=14, AE_THRESH=2; write 0x00..0x0F on 16 consecutive cycles.
  - Required: count steps 1..16; almost_empty deasserts at count 3; almost_full asserts at count 14; full asserts at count 16; overflow stays 0.
- Drain and wrap: write 10 entries, read 10, write 0xA0..0xAF.
  - Required: pointers wrap; reads return 0xA0..0xAF in order; standard mode data is valid one edge after each read.
- Simultaneous read and write:
  - At full: count goes 16 -> 15 and overflow=1.
  - At empty: count goes 0 -> 1 and underflow=1.
  - At count=5: count stays 5 and the data order is preserved.
- Flush with pending write: count=7, then flush=1 and write=1 in the same cycle.
  - Required: count=0, empty=1, error flags cleared, written word discarded.
- Async reset mid-burst: assert rst between clock edges at count=9.
  - Required: count=0, empty=1 and data_out=0 before the next clock edge.
- FWFT build (FIFO_FWFT_EN defined): write 0x5A into an empty FIFO.
  - Required: data_out=0x5A the cycle after the write, with no read issued; a read then gives empty=1 and data_out=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
//
// Optional build macro: FIFO_FWFT_EN
//   defined   -> first-word-fall-through: data_out shows the head entry
//                combinationally while not empty, 0 when empty.
//   undefined -> registered read: data_out loads on each accepted read and
//                holds until the next one.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous clear of pointers, count and error flags
//   data_in      write data
//   write        write request (accepted when not full)
//   read         read request (accepted when not empty)
//   data_out     read data
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        current occupancy
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty

module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         write,
    input  logic                         read,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    // Requests are judged against the flags of the current count, so a
    // write at full is refused even when a read frees a slot this cycle.
    assign wr_en = write && !full && !flush;
    assign rd_en = read && !empty && !flush;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (write && full) begin
                overflow <= 1'b1;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (flush) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_ptr];
        end
    end

    assign data_out = rd_data;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16, AF=14, AE=2).
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [DW-1:0] data_in;
    logic          write;
    logic          read;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: entries pushed when an accepted write is driven, popped
    // when the corresponding read is driven.
    logic [DW-1:0] mq[$];
    bit            movf;
    bit            munf;
    logic [DW-1:0] mdata;

    typedef struct {
        bit            w;
        bit            r;
        bit            f;
        logic [DW-1:0] d;
        int            cnt;
        bit            full;
        bit            af;
        bit            ae;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int exp_data();
`ifdef FIFO_FWFT_EN
        return (mq.size() != 0) ? int'(mq[0]) : 0;
`else
        return int'(mdata);
`endif
    endfunction

    task automatic check_state(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"},     int'(count),        n);
        chk({tag, ".full"},      int'(full),         int'(n == DEPTH));
        chk({tag, ".empty"},     int'(empty),        int'(n == 0));
        chk({tag, ".af"},        int'(almost_full),  int'(n >= AF));
        chk({tag, ".ae"},        int'(almost_empty), int'(n <= AE));
        chk({tag, ".overflow"},  int'(overflow),     int'(movf));
        chk({tag, ".underflow"}, int'(underflow),    int'(munf));
        chk({tag, ".data_out"},  int'(data_out),     exp_data());
    endtask

    task automatic model_reset();
        mq.delete();
        movf  = 1'b0;
        munf  = 1'b0;
        mdata = '0;
    endtask

    // One clock cycle: update the model from the requests, clock the DUT,
    // then compare just after the edge.
    task automatic step(input string tag, input bit w, input bit r, input bit f,
                        input logic [DW-1:0] d);
        bit mfull;
        bit mempty;
        write   = w;
        read    = r;
        flush   = f;
        data_in = d;
        mfull   = (mq.size() == DEPTH);
        mempty  = (mq.size() == 0);
        if (f) begin
            model_reset();
        end else begin
            if (w && mfull)  movf = 1'b1;
            if (r && mempty) munf = 1'b1;
            if (r && !mempty) mdata = mq.pop_front();
            if (w && !mfull) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
        check_state(tag);
    endtask

    initial begin
        // Reset then fill 0x00..0x0F, then read+write at full.
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{w: 1'b1, r: 1'b0, f: 1'b0, d: 8'(i), cnt: i + 1,
                        full: (i == 15), af: (i + 1 >= AF), ae: (i + 1 <= AE)};
        end
        vecs[16] = '{w: 1'b1, r: 1'b1, f: 1'b0, d: 8'h77, cnt: 15,
                     full: 1'b0, af: 1'b1, ae: 1'b0};

        rst     = 1'b1;
        flush   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;
        model_reset();
        #12;
        check_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step("fill", vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].d);
            chk("tbl.count", int'(count),        vecs[i].cnt);
            chk("tbl.full",  int'(full),         int'(vecs[i].full));
            chk("tbl.af",    int'(almost_full),  int'(vecs[i].af));
            chk("tbl.ae",    int'(almost_empty), int'(vecs[i].ae));
        end
        chk("rw_full.overflow", int'(overflow), 1);

        // Drain the remaining 15 entries.
        for (int i = 0; i < 15; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);

        // Read+write at empty.
        step("rw_empty", 1'b1, 1'b1, 1'b0, 8'h33);
        chk("rw_empty.count", int'(count), 1);
        chk("rw_empty.underflow", int'(underflow), 1);
        step("rw_empty_rd", 1'b0, 1'b1, 1'b0, '0);

        // Drain and wrap.
        for (int i = 0; i < 10; i++) step("wrap_wr", 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) step("wrap_rd", 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 16; i++) step("wrap_wa", 1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 16; i++) begin
            step("wrap_ra", 1'b0, 1'b1, 1'b0, '0);
`ifndef FIFO_FWFT_EN
            chk("wrap_ra.order", int'(data_out), 8'hA0 + i);
`endif
        end

        // Read+write at count 5.
        for (int i = 0; i < 5; i++) step("mid_wr", 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) begin
            step("mid_rw", 1'b1, 1'b1, 1'b0, 8'(8'hD0 + i));
            chk("mid_rw.count", int'(count), 5);
        end
        for (int i = 0; i < 5; i++) step("mid_rd", 1'b0, 1'b1, 1'b0, '0);

        // Flush with a pending write at count 7; error flags are set here.
        for (int i = 0; i < 7; i++) step("fl_wr", 1'b1, 1'b0, 1'b0, 8'(8'hE0 + i));
        step("flush", 1'b1, 1'b0, 1'b1, 8'hEE);
        chk("flush.count", int'(count), 0);
        chk("flush.empty", int'(empty), 1);
        chk("flush.overflow", int'(overflow), 0);
        chk("flush.underflow", int'(underflow), 0);
        step("fl_post_wr", 1'b1, 1'b0, 1'b0, 8'h11);
        step("fl_post_rd", 1'b0, 1'b1, 1'b0, '0);

        // Async reset between edges at count 9.
        for (int i = 0; i < 10; i++) step("ar_wr", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        step("ar_rd", 1'b0, 1'b1, 1'b0, '0);
        chk("ar.count_pre", int'(count), 9);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.count", int'(count), 0);
        chk("async_rst.empty", int'(empty), 1);
        chk("async_rst.data_out", int'(data_out), 0);
        check_state("async_rst");
        #1;
        rst = 1'b0;

        // Write into empty, then read it back.
        step("fw_wr", 1'b1, 1'b0, 1'b0, 8'h5A);
`ifdef FIFO_FWFT_EN
        chk("fwft.data_out_wr", int'(data_out), 8'h5A);
`endif
        step("fw_rd", 1'b0, 1'b1, 1'b0, '0);
        chk("fw_rd.empty", int'(empty), 1);
`ifdef FIFO_FWFT_EN
        chk("fwft.data_out_rd", int'(data_out), 0);
`else
        chk("std.data_out_rd", int'(data_out), 8'h5A);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
